// File: rtl/fps_seq_pkg.sv
// fps_pkg: state encoding, registered-output bundle, default iteration limits and saturating increment
package fps_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_F1, S_F2, S_F4, S_F5, S_F6, S_F7, S_F8, S_F9, S_F10, S_F13, S_END
  } state_t;
  localparam int NORM_LIMIT_DEF = 40;
  localparam int LOOP_LIMIT_DEF = 63;
  typedef struct packed {
    logic f2, f4, f5, f6, f7, f8, f10, f9, f13, strob, strob2, clr0, busy, done, err;
  } out_t;
  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return &v ? v : v + 6'd1;
  endfunction
endpackage

// File: rtl/fps_seq_if.sv
// fps_if: start/class/F-PM status inputs and phase-line/strobe/completion outputs of fps_seq
interface fps_if;
  logic start, ss, af_sf, mw_mf, dw_df, fic_z, g, ok, nz;
  logic f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13, strob_fp, strob2_fp, _0_f, busy, done, err;
  modport slave (
    input  start, ss, af_sf, mw_mf, dw_df, fic_z, g, ok, nz,
    output f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13, strob_fp, strob2_fp, _0_f, busy, done, err
  );
  modport master (
    output start, ss, af_sf, mw_mf, dw_df, fic_z, g, ok, nz,
    input  f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13, strob_fp, strob2_fp, _0_f, busy, done, err
  );
endinterface

// File: rtl/fps_seq_itcnt.sv
// fps_itcnt: 6-bit clear/increment/saturate counter; hit = post-increment value has reached limit
module fps_itcnt
  import fps_pkg::*;
(
  input  logic       clk,
  input  logic       rst_,
  input  logic       clr,
  input  logic       inc,
  input  logic [5:0] limit,
  output logic       hit
);
  logic [5:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? 6'd0 : inc ? sat_inc(cnt_q) : cnt_q;
  assign hit = sat_inc(cnt_q) >= limit;
  always_ff @(posedge clk) cnt_q <= !rst_ ? 6'd0 : cnt_d;
endmodule

// File: rtl/fps_seq.sv
// fps_seq: FPU phase sequencer; ports __clk, rst_ (sync active-low), bus (fps_if.slave: start/class/status in, phases/strobes/done/err out)
module fps_seq
  import fps_pkg::*;
#(
  parameter int NORM_LIMIT = NORM_LIMIT_DEF,
  parameter int LOOP_LIMIT = LOOP_LIMIT_DEF
) (
  input logic  __clk,
  input logic  rst_,
  fps_if.slave bus
);
  state_t state_q, state_d;
  logic sub_q, sub_d, err_q, err_d, clr, inc, hit, ph;
  logic [5:0] limit;
  out_t out_q, out_d;
  assign limit = state_q == S_F8 ? 6'(LOOP_LIMIT) : 6'(NORM_LIMIT);
  assign clr = state_d != state_q && (state_d == S_F8 || state_d == S_F10);
  fps_itcnt u_itcnt (.clk(__clk), .rst_(rst_), .clr(clr), .inc(inc), .limit(limit), .hit(hit));
  always_comb begin
    state_d = state_q;
    sub_d = 1'b0;
    err_d = err_q;
    inc = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.start) begin
        state_d = S_F1;
        err_d = 1'b0;
      end
    end else if (state_q == S_END) state_d = S_IDLE;
    else if (!sub_q) sub_d = 1'b1;
    else
      case (state_q)
        S_F1: state_d = S_F2;
        S_F2: state_d = S_F4;
        S_F4: state_d = bus.af_sf ? S_F5 : (bus.mw_mf | bus.dw_df) ? S_F8 : S_F6;
        S_F5: state_d = bus.g ? S_F10 : bus.fic_z ? S_F6 : S_F8;
        S_F6: state_d = S_F7;
        S_F7, S_F9: state_d = bus.ss ? S_END : S_F10;
        S_F8: begin
          inc = 1'b1;
          if (bus.fic_z) state_d = bus.af_sf ? S_F6 : bus.dw_df ? S_F9 : S_F10;
          else if (hit) begin
            state_d = S_END;
            err_d = 1'b1;
          end
        end
        S_F10: begin
          inc = 1'b1;
          if (bus.ok || !bus.nz) state_d = S_F13;
          else if (hit) begin
            state_d = S_F13;
            err_d = 1'b1;
          end
        end
        default: state_d = S_END;
      endcase
  end
  assign ph = !(state_q inside {S_IDLE, S_F1, S_END});
  always_comb begin
    out_d = '0;
    out_d.f2 = state_q == S_F2;
    out_d.f4 = state_q == S_F4;
    out_d.f5 = state_q == S_F5;
    out_d.f6 = state_q == S_F6;
    out_d.f7 = state_q == S_F7;
    out_d.f8 = state_q == S_F8;
    out_d.f10 = state_q == S_F10;
    out_d.f9 = state_q == S_F9;
    out_d.f13 = state_q == S_F13;
    out_d.strob = ph && !sub_q;
    out_d.strob2 = ph && sub_q;
    out_d.clr0 = state_q == S_F1;
    out_d.busy = state_q != S_IDLE;
    out_d.done = state_q == S_END;
    out_d.err = err_q;
  end
  always_ff @(posedge __clk)
    if (!rst_) begin
      state_q <= S_IDLE;
      sub_q <= 1'b0;
      err_q <= 1'b0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      sub_q <= sub_d;
      err_q <= err_d;
      out_q <= out_d;
    end
  assign bus.f2_ = ~out_q.f2;
  assign bus.f4_ = ~out_q.f4;
  assign bus.f5_ = ~out_q.f5;
  assign bus.f6_ = ~out_q.f6;
  assign bus.f7_ = ~out_q.f7;
  assign bus.f8_ = ~out_q.f8;
  assign bus.f10_ = ~out_q.f10;
  assign bus.f9 = out_q.f9;
  assign bus.f13 = out_q.f13;
  assign bus.strob_fp = out_q.strob;
  assign bus.strob2_fp = out_q.strob2;
  assign bus._0_f = out_q.clr0;
  assign bus.busy = out_q.busy;
  assign bus.done = out_q.done;
  assign bus.err = out_q.err;
endmodule

// File: tb/tb_fps_seq.sv
// tb_fps_seq: directed instruction runs checked cycle-by-cycle against a phase-list model of the sequencer
module tb_fps_seq;
  logic clk = 0, rst_ = 0;
  always #5 clk = ~clk;
  fps_if fif ();
  fps_seq dut (.__clk(clk), .rst_(rst_), .bus(fif));
  typedef enum {P_F1, P_F2, P_F4, P_F5, P_F6, P_F7, P_F8, P_F9, P_F10, P_F13, P_END} ph_t;
  ph_t st_q[$];
  bit sb_q[$];
  bit er_q[$];
  logic [2:0] in_q[$];
  int checks = 0, errors = 0, cyc = 0, t0 = 0, len = 0;
  int done_at, n_f8, n_f10, n_done;
  bit run_on = 0, e = 0, err_done;
  logic [14:0] dv;
  localparam logic [14:0] IDLE_V = {7'h7f, 8'h00};
  assign dv = {fif.f2_, fif.f4_, fif.f5_, fif.f6_, fif.f7_, fif.f8_, fif.f10_, fif.f9, fif.f13,
               fif.strob_fp, fif.strob2_fp, fif._0_f, fif.busy, fif.done, fif.err};
  always @(posedge clk) cyc <= cyc + 1;
  task automatic push(input ph_t p, input logic [2:0] b);
    if (p == P_END) begin
      st_q.push_back(p); sb_q.push_back(1'b0); er_q.push_back(e); in_q.push_back(3'b000);
    end else
      for (int s = 0; s < 2; s++) begin
        st_q.push_back(p); sb_q.push_back(s == 1); er_q.push_back(e); in_q.push_back(s == 1 ? b : ~b);
      end
  endtask
  function automatic logic [14:0] expv(input int k);
    ph_t p;
    bit a, ph;
    if (k > len) return {7'h7f, 7'h00, e};
    p = st_q[k-1];
    a = sb_q[k-1];
    ph = !(p inside {P_F1, P_END});
    return {p != P_F2, p != P_F4, p != P_F5, p != P_F6, p != P_F7, p != P_F8, p != P_F10,
            p == P_F9, p == P_F13, ph && !a, ph && a, p == P_F1, 1'b1, p == P_END, er_q[k-1]};
  endfunction
  always @(negedge clk) begin
    int k;
    k = cyc - t0;
    if (run_on && k >= 1 && k <= len + 1) begin
      checks++;
      if (dv !== expv(k)) begin
        errors++;
        $display("FAIL out k=%0d got %b exp %b", k, dv, expv(k));
      end
      if (fif.done) begin
        done_at = k;
        err_done = fif.err;
      end
      if (!fif.f8_) n_f8++;
      if (!fif.f10_) n_f10++;
    end
  end
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, want);
    end
  endtask
  task automatic chkv(input string name, input logic [14:0] got, input logic [14:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b exp %b", name, got, want);
    end
  endtask
  task automatic run(input string name, input bit ss, af, mw, dw, gg, f5fz, input int n8, n10,
                     input bit by_ok, hold, input int w_done, w_f8, w_f10, w_err);
    ph_t nx;
    st_q.delete(); sb_q.delete(); er_q.delete(); in_q.delete();
    e = 0;
    push(P_F1, 3'b0); push(P_F2, 3'b0); push(P_F4, 3'b0);
    nx = af ? P_F5 : (mw | dw) ? P_F8 : P_F6;
    while (nx != P_END)
      case (nx)
        P_F5: begin
          push(P_F5, {f5fz, 2'b00});
          nx = gg ? P_F10 : f5fz ? P_F6 : P_F8;
        end
        P_F8:
          for (int it = 1; it <= 63; it++) begin
            if (it == n8) begin
              push(P_F8, 3'b100);
              nx = af ? P_F6 : dw ? P_F9 : P_F10;
              break;
            end
            push(P_F8, 3'b000);
            if (it == 63) begin
              e = 1;
              nx = P_END;
            end
          end
        P_F6: begin
          push(P_F6, 3'b0);
          nx = P_F7;
        end
        P_F7, P_F9: begin
          push(nx, 3'b0);
          nx = ss ? P_END : P_F10;
        end
        P_F10:
          for (int it = 1; it <= 40; it++) begin
            if (it == n10) begin
              push(P_F10, by_ok ? 3'b011 : 3'b000);
              nx = P_F13;
              break;
            end
            push(P_F10, 3'b001);
            if (it == 40) begin
              e = 1;
              nx = P_F13;
            end
          end
        default: begin
          push(P_F13, 3'b0);
          nx = P_END;
        end
      endcase
    push(P_END, 3'b0);
    len = st_q.size();
    fif.ss = ss; fif.af_sf = af; fif.mw_mf = mw; fif.dw_df = dw; fif.g = gg;
    done_at = -1; n_f8 = 0; n_f10 = 0; err_done = 0;
    @(negedge clk);
    fif.start = 1;
    t0 = cyc + 1;
    run_on = 1;
    for (int n = 0; n <= len + 1; n++) begin
      @(negedge clk);
      {fif.fic_z, fif.ok, fif.nz} = n < len ? in_q[n] : 3'b000;
      fif.start = hold && n < len;
    end
    @(negedge clk);
    run_on = 0;
    chk({name, " len"}, len, w_done);
    chk({name, " done_at"}, done_at, w_done);
    chk({name, " f8_cycles"}, n_f8, w_f8);
    chk({name, " f10_cycles"}, n_f10, w_f10);
    chk({name, " err"}, int'(err_done), w_err);
  endtask
  initial begin
    {fif.start, fif.ss, fif.af_sf, fif.mw_mf, fif.dw_df, fif.fic_z, fif.g, fif.ok, fif.nz} = '0;
    repeat (3) @(negedge clk);
    chkv("reset_held", dv, IDLE_V);
    rst_ = 1;
    @(negedge clk);
    chkv("reset_release", dv, IDLE_V);
    run("ad",        1, 0, 0, 0, 0, 0, 0, 0, 1, 0,  11,   0,  0, 0);
    run("sd",        0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  15,   0,  2, 0);
    run("mf",        0, 0, 1, 0, 0, 0, 3, 1, 1, 0,  17,   6,  2, 0);
    run("af_g",      0, 1, 0, 0, 1, 0, 0, 1, 1, 0,  13,   0,  2, 0);
    run("norm_lim",  0, 1, 0, 0, 1, 0, 0, 0, 1, 0,  91,   0, 80, 1);
    run("loop_lim",  0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 133, 126,  0, 1);
    run("af_f5fz",   0, 1, 0, 0, 0, 1, 0, 2, 0, 0,  19,   0,  4, 0);
    run("af_f8",     1, 1, 0, 0, 0, 0, 2, 0, 1, 1,  17,   4,  0, 0);
    run("dw_f9",     0, 0, 0, 1, 0, 0, 1, 3, 1, 0,  19,   2,  6, 0);
    run("dw_ss",     1, 0, 0, 1, 0, 0, 2, 0, 1, 1,  13,   4,  0, 0);
    fif.ss = 0; fif.af_sf = 0; fif.mw_mf = 1; fif.dw_df = 0; fif.g = 0;
    {fif.fic_z, fif.ok, fif.nz} = 3'b000;
    @(negedge clk);
    fif.start = 1;
    @(negedge clk);
    fif.start = 0;
    repeat (9) @(negedge clk);
    chk("mid_f8_active", int'(fif.f8_), 0);
    rst_ = 0;
    @(negedge clk);
    chkv("mid_reset", dv, IDLE_V);
    rst_ = 1;
    fif.fic_z = 1;
    n_done = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (fif.done) n_done++;
      chkv("post_reset_idle", dv, IDLE_V);
    end
    chk("no_done_after_reset", n_done, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
